multi_trigger_counter: RTL

MULTI_TRIGGER_COUNTER -- requirements
Module: multi_trigger_counter

---
 rtl/multi_trigger_counter.sv | 118 +++++++++++
 1 files changed

// File: rtl/multi_trigger_counter.sv
// Multi-channel triggered counter with a shared, runtime-loadable terminal bound.
// Define MULTI_TRIG_SYNC_EN to place a 2-flop synchronizer on each trigger bit.
module multi_trigger_counter #(
   parameter int W         = 4,
   parameter int NCH       = 2,
   parameter int DEF_BOUND = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NCH-1:0]   trigger,
   input  logic [NCH-1:0]   mode,
   input  logic [NCH-1:0]   abort,
   input  logic [W-1:0]     bound,
   input  logic             bound_load,
   output logic [NCH*W-1:0] count,
   output logic [NCH-1:0]   busy,
   output logic [NCH-1:0]   done
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   logic [NCH-1:0] trig_s;
   logic [NCH-1:0] trig_prev;
   logic [NCH-1:0] rise;
   logic [W-1:0]   bound_reg;

`ifdef MULTI_TRIG_SYNC_EN
   // trigger may be asynchronous to clk in this build
   logic [NCH-1:0] sync_p0;
   logic [NCH-1:0] sync_p1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= trigger;
         sync_p1 <= sync_p0;
      end
   end

   assign trig_s = sync_p1;
`else
   assign trig_s = trigger;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         trig_prev <= '0;
      end else begin
         trig_prev <= trig_s;
      end
   end

   assign rise = trig_s & ~trig_prev;

   // A zero bound would make the channel terminate every cycle, so it is refused
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bound_reg <= W'(DEF_BOUND);
      end else if (bound_load && (bound != '0)) begin
         bound_reg <= bound;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      state_t       state_q;
      state_t       state_d;
      logic [W-1:0] cnt_q;
      logic [W-1:0] cnt_d;
      logic         done_q;
      logic         done_d;
      logic         busy_c;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
         end
      end

      // Terminal test is >= so a bound lowered beneath a running count still ends the run
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         done_d  = 1'b0;
         if (abort[i]) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else if (state_q == IDLE) begin
            cnt_d = '0;
            if (rise[i]) begin
               state_d = RUN;
            end
         end else if (cnt_q >= bound_reg) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = mode[i] ? RUN : IDLE;
         end else begin
            cnt_d = cnt_q + W'(1);
         end
      end

      always_comb begin
         busy_c = (state_q == RUN);
      end

      assign busy[i]          = busy_c;
      assign done[i]          = done_q;
      assign count[i*W +: W]  = cnt_q;
   end

endmodule
